minrv32_dmem_responder: RTL and testbench
=========================================

// Module: minrv32_dmem_responder
// PURPOSE
//  Data-memory target for the minrv32 mem_* bus: the responder end of the core's load/store port.
//  Holds a word-organised RAM with byte-lane writes and a programmable wait-state counter.
//  Realigns byte/half data between the core's low-justified lanes and the address-selected RAM lanes.
//  Sits between the core's mem_* outputs and the system bus / testbench memory.
// PARAMETERS
//  DEPTH_WORDS  1024          RAM size in 32-bit words (power of two, >=4)
//  BASE_ADDR    32'h0000_0000 byte address of word 0 (word aligned)
//  WAIT_STATES  0             extra cycles inserted before mem_ready (0..15)
// PORTS
//  clk        in   1   clock, all state on rising edge
//  reset      in   1   synchronous, active-high reset
//  mem_valid  in   1   request present; initiator holds it and all request fields until mem_ready
//  mem_instr  in   1   fetch qualifier; accepted and ignored
//  mem_ready  out  1   one-cycle completion pulse
//  mem_addr   in   32  byte address
//  mem_wdata  in   32  store data, low-justified (SB in [7:0], SH in [15:0])
//  mem_wstrb  in   4   store lanes, low-justified (0001/0011/1111); nonzero = write
//  mem_rmask  in   4   load lanes, low-justified (0001/0011/1111)
//  mem_rdata  out  32  load data, low-justified, raw (core sign/zero-extends); valid only with mem_ready
//  mem_err    out  1   error flag, valid only with mem_ready (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE, wait counter 0, mem_ready 0, mem_rdata 0, mem_err 0. RAM contents retained.
//  - FSM IDLE -> WAIT -> RESP -> IDLE:
//    IDLE: mem_valid=1 at cycle T latches addr/wdata/wstrb/rmask; go to WAIT with cnt=WAIT_STATES,
//      or straight to RESP when WAIT_STATES=0.
//    WAIT: cnt decrements each cycle; at cnt==1 go to RESP.
//    RESP: mem_ready=1 (exactly 1 cycle, at T+1+WAIT_STATES); mem_rdata/mem_err valid; then IDLE.
//  - Throughput: one access per 2+WAIT_STATES cycles. mem_valid seen in the RESP cycle is not a
//    new request; a new request is accepted in IDLE from T+2+WAIT_STATES.
//  - Outputs are registered; mem_ready, mem_rdata, mem_err return to 0 the cycle after RESP.
//  - Decode: off = addr[1:0]; word = (addr - BASE_ADDR) >> 2; hit = addr >= BASE_ADDR && word < DEPTH_WORDS.
//  - Lane shift: wlanes = {4'b0,wstrb} << off; rlanes = {4'b0,rmask} << off (8-bit results).
//    cross = |lanes[7:4] (access spans a word boundary).
//  - Write (wstrb!=0): commit in the RESP cycle to RAM[word] byte k where wlanes[k]=1 (k<4),
//    data = (wdata << 8*off) byte k. mem_rdata=0. A miss writes nothing.
//  - Read (wstrb==0): mem_rdata = (RAM[word] >> 8*off) masked to rmask lanes; unmasked lanes read 0.
//    Lanes beyond byte 3 read 0. A miss returns 0. rmask==0 and wstrb==0: no-op, mem_rdata=0.
//  - Write value is sampled at the RESP commit edge; RAM read uses the pre-commit value
//    (read-before-write within the same request).
//  - Request fields are latched in IDLE; changes during WAIT/RESP are ignored.
//  - Reset in WAIT: no write. Reset in RESP: the write in that cycle is dropped. Either case returns to IDLE.
//  - Wait counter is 4 bits wide; no wrap, because WAIT_STATES<=15.
// CONFIGURATION
//  MINRV32_DMEM_ERR_EN defined: mem_err=1 in RESP when !hit, or cross=1, or wstrb/rmask is not
//    0000/0001/0011/1111. An erroring write commits no lanes.
//  Not defined: mem_err is tied to 0. A crossing write commits only in-word lanes (k<4).
//    A miss or odd mask is silently handled as above.
// TESTING
//  1 W=0: SW 0x100 data 0xDEADBEEF, then LW 0x100 -> ready at T+1 each; rdata=0xDEADBEEF, err=0
//  2 SB 0x103 data 0x000000AA over 0x11223344; LW 0x100 -> 0xAA223344; LB 0x103 -> rdata=0x000000AA
//  3 W=3: LH 0x102 on word 0xCAFE1234 -> ready exactly at T+4, one cycle, rdata=0x0000CAFE;
//    mem_valid held through the access gives one response only
//  4 SH 0x103 (crossing) data 0xBBCC on 0 -> ERR_EN: err=1 and word stays 0;
//    no ERR_EN: word=0xCC000000, err=0
//  5 LW at BASE_ADDR+4*DEPTH_WORDS -> rdata=0; err=1 only with ERR_EN; RAM unchanged
//  6 W=2: SW 0x10 data 0x5 with reset pulsed in WAIT -> no ready; a following LW 0x10 returns the old value

Source files
------------

// File: rtl/minrv32_dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : minrv32_dmem_responder                                     |
// | Description : Data-memory responder for the minrv32 mem_* bus. Holds a   |
// |               word-organised RAM with byte-lane writes and a wait-state  |
// |               counter. It realigns low-justified core lanes to the       |
// |               address-selected RAM lanes.                                |
// | Option      : `define MINRV32_DMEM_ERR_EN to report misses, word-        |
// |               crossing accesses and odd lane masks on mem_err. Flagged   |
// |               writes are suppressed. When the macro is undefined,        |
// |               mem_err is tied to 0.                                      |
// | Ports       : clk, reset (sync, active-high)                             |
// |               mem_valid/mem_instr/mem_addr/mem_wdata/mem_wstrb/mem_rmask |
// |                 request inputs, held by the initiator until mem_ready    |
// |               mem_ready/mem_rdata/mem_err  registered response outputs   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module minrv32_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  input  logic [3:0]  mem_rmask,
  output logic [31:0] mem_rdata,
  output logic        mem_err
);

  localparam int         AW         = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_WAIT_CNT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_wstrb, r_rmask;
  logic        r_ready, r_err;
  logic [31:0] r_rdata;
  logic        w_ready_nxt, w_err_nxt, w_latch, w_enter_resp;
  logic [31:0] w_rdata_nxt;

  logic [31:0] r_mem [DEPTH_WORDS];

  // In IDLE the live request is decoded so a zero-wait access can load its
  // response on the accepting edge; afterwards the latched copy is used.
  logic        w_idle;
  logic [31:0] w_addr, w_wdata, w_offs;
  logic [3:0]  w_wstrb, w_rmask;
  logic [1:0]  w_off;
  logic [29:0] w_word;
  logic [AW-1:0] w_idx;
  logic        w_hit, w_is_wr, w_cross, w_err;
  logic [7:0]  w_wlanes, w_rlanes;
  logic [31:0] w_rd_shift, w_rd_mask, w_rd_val, w_wr_shift;
  logic [3:0]  w_we;
  logic        w_unused;

  assign w_idle  = (r_state == S_IDLE);
  assign w_addr  = w_idle ? mem_addr  : r_addr;
  assign w_wdata = w_idle ? mem_wdata : r_wdata;
  assign w_wstrb = w_idle ? mem_wstrb : r_wstrb;
  assign w_rmask = w_idle ? mem_rmask : r_rmask;

  assign w_offs  = w_addr - BASE_ADDR;
  assign w_off   = w_offs[1:0];
  assign w_word  = w_offs[31:2];
  assign w_idx   = w_word[AW-1:0];
  assign w_hit   = (w_addr >= BASE_ADDR) && ({2'b00, w_word} < 32'(DEPTH_WORDS));
  assign w_is_wr = |w_wstrb;

  assign w_wlanes = {4'b0000, w_wstrb} << w_off;
  assign w_rlanes = {4'b0000, w_rmask} << w_off;
  assign w_cross  = w_is_wr ? |w_wlanes[7:4] : |w_rlanes[7:4];

`ifdef MINRV32_DMEM_ERR_EN
  function automatic logic legal_mask(input logic [3:0] m);
    return (m == 4'b0000) || (m == 4'b0001) || (m == 4'b0011) || (m == 4'b1111);
  endfunction
  assign w_err = !w_hit || w_cross || !legal_mask(w_wstrb) || !legal_mask(w_rmask);
`else
  assign w_err = 1'b0;
`endif

  // Right shift pulls zeros into lanes past byte 3, so crossing reads
  // return 0 in those lanes without extra masking.
  assign w_rd_shift = r_mem[w_idx] >> {w_off, 3'b000};
  assign w_rd_mask  = {{8{w_rmask[3]}}, {8{w_rmask[2]}}, {8{w_rmask[1]}}, {8{w_rmask[0]}}};
  assign w_rd_val   = (w_is_wr || !w_hit) ? 32'h0 : (w_rd_shift & w_rd_mask);
  assign w_wr_shift = w_wdata << {w_off, 3'b000};

  // Only in-word lanes commit, and a reset in the RESP cycle drops the write.
  assign w_we = (r_state == S_RESP && !reset && w_is_wr && w_hit && !w_err)
              ? w_wlanes[3:0] : 4'b0000;

  assign w_unused = ^{mem_instr, w_cross, w_rlanes[3:0], w_wlanes[7:4]};

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (w_we[k]) begin
        r_mem[w_idx][8*k +: 8] <= w_wr_shift[8*k +: 8];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_latch      = 1'b0;
    w_enter_resp = 1'b0;
    w_ready_nxt  = 1'b0;
    w_rdata_nxt  = 32'h0;
    w_err_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_valid) begin
          w_latch = 1'b1;
          if (c_WAIT_CNT == 4'd0) begin
            w_state_nxt  = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = c_WAIT_CNT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt  = S_RESP;
          w_cnt_nxt    = 4'd0;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = 4'(r_cnt - 4'd1);
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_enter_resp) begin
      w_ready_nxt = 1'b1;
      w_rdata_nxt = w_rd_val;
      w_err_nxt   = w_err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_ready <= 1'b0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_wstrb <= 4'h0;
      r_rmask <= 4'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
      r_rdata <= w_rdata_nxt;
      r_err   <= w_err_nxt;
      if (w_latch) begin
        r_addr  <= mem_addr;
        r_wdata <= mem_wdata;
        r_wstrb <= mem_wstrb;
        r_rmask <= mem_rmask;
      end
    end
  end

  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;
  assign mem_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_minrv32_dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_minrv32_dmem_responder                                  |
// | Description : Scoreboard bench for minrv32_dmem_responder. It uses three |
// |               instances with wait states 0, 3 and 2.                     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_minrv32_dmem_responder;

`ifdef MINRV32_DMEM_ERR_EN
  localparam bit c_ERR = 1'b1;
`else
  localparam bit c_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic [2:0]  v, rdy, er;
  logic [31:0] a [3];
  logic [31:0] wd [3];
  logic [3:0]  ws [3];
  logic [3:0]  rm [3];
  logic [31:0] rd [3];

  int n_total = 0;
  int n_bad   = 0;
  logic [32:0] sbq [$];

  always #5 clk = ~clk;

  minrv32_dmem_responder #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(rst), .mem_valid(v[0]), .mem_instr(1'b0), .mem_ready(rdy[0]),
    .mem_addr(a[0]), .mem_wdata(wd[0]), .mem_wstrb(ws[0]), .mem_rmask(rm[0]),
    .mem_rdata(rd[0]), .mem_err(er[0]));

  minrv32_dmem_responder #(.WAIT_STATES(3)) u_dut3 (
    .clk(clk), .reset(rst), .mem_valid(v[1]), .mem_instr(1'b0), .mem_ready(rdy[1]),
    .mem_addr(a[1]), .mem_wdata(wd[1]), .mem_wstrb(ws[1]), .mem_rmask(rm[1]),
    .mem_rdata(rd[1]), .mem_err(er[1]));

  minrv32_dmem_responder #(.WAIT_STATES(2)) u_dut2 (
    .clk(clk), .reset(rst2), .mem_valid(v[2]), .mem_instr(1'b0), .mem_ready(rdy[2]),
    .mem_addr(a[2]), .mem_wdata(wd[2]), .mem_wstrb(ws[2]), .mem_rmask(rm[2]),
    .mem_rdata(rd[2]), .mem_err(er[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives one request at a negedge, holds it until mem_ready, then compares
  // the response against the scoreboard entry and checks latency and pulse width.
  task automatic access(input int i, input string tag, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input logic [3:0] rmask, input logic [31:0] exp_rd,
                        input logic exp_er, input int exp_lat);
    logic [32:0] e;
    int lat;
    bit seen;
    v[i] = 1'b1; a[i] = addr; wd[i] = wdata; ws[i] = wstrb; rm[i] = rmask;
    sbq.push_back({exp_er, exp_rd});
    @(posedge clk);
    seen = 1'b0;
    lat  = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rdy[i]) begin
        seen = 1'b1;
        lat  = n;
        break;
      end
    end
    v[i] = 1'b0; ws[i] = 4'h0; rm[i] = 4'h0;
    e = sbq.pop_front();
    if (!seen) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_rdata"}, rd[i], e[31:0]);
      check({tag, "_err"}, {31'b0, er[i]}, {31'b0, e[32]});
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    end
    @(negedge clk);
    check({tag, "_pulse"}, {31'b0, rdy[i]}, 32'd0);
  endtask

  initial begin
    logic any;
    rst = 1'b1; rst2 = 1'b1; v = 3'b000;
    for (int i = 0; i < 3; i++) begin
      a[i] = 32'h0; wd[i] = 32'h0; ws[i] = 4'h0; rm[i] = 4'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_ready%0d", i), {31'b0, rdy[i]}, 32'd0);
      check($sformatf("reset_rdata%0d", i), rd[i], 32'd0);
      check($sformatf("reset_err%0d", i), {31'b0, er[i]}, 32'd0);
    end

    // Zero wait states: word store and load.
    access(0, "t1_sw", 32'h100, 32'hDEADBEEF, 4'hF, 4'h0, 32'h0, 1'b0, 0);
    access(0, "t1_lw", 32'h100, 32'h0, 4'h0, 4'hF, 32'hDEADBEEF, 1'b0, 0);

    // Byte store into lane 3, then word and byte loads.
    access(0, "t2_sw", 32'h100, 32'h11223344, 4'hF, 4'h0, 32'h0, 1'b0, 0);
    access(0, "t2_sb", 32'h103, 32'h000000AA, 4'h1, 4'h0, 32'h0, 1'b0, 0);
    access(0, "t2_lw", 32'h100, 32'h0, 4'h0, 4'hF, 32'hAA223344, 1'b0, 0);
    access(0, "t2_lb", 32'h103, 32'h0, 4'h0, 4'h1, 32'h000000AA, 1'b0, 0);
    access(0, "t2_lh", 32'h102, 32'h0, 4'h0, 4'h3, 32'h0000AA22, 1'b0, 0);

    // Crossing halfword store.
    access(0, "t4_clr", 32'h200, 32'h0, 4'hF, 4'h0, 32'h0, 1'b0, 0);
    access(0, "t4_sh", 32'h203, 32'h0000BBCC, 4'h3, 4'h0, 32'h0, c_ERR, 0);
    access(0, "t4_lw", 32'h200, 32'h0, 4'h0, 4'hF, c_ERR ? 32'h0 : 32'hCC000000, 1'b0, 0);

    // Out-of-range accesses must not alias word 0.
    access(0, "t5_sw0", 32'h0, 32'h12345678, 4'hF, 4'h0, 32'h0, 1'b0, 0);
    access(0, "t5_lwx", 32'h1000, 32'h0, 4'h0, 4'hF, 32'h0, c_ERR, 0);
    access(0, "t5_swx", 32'h1000, 32'hFFFFFFFF, 4'hF, 4'h0, 32'h0, c_ERR, 0);
    access(0, "t5_lw0", 32'h0, 32'h0, 4'h0, 4'hF, 32'h12345678, 1'b0, 0);

    // Three wait states: the held request yields a single response at T+4.
    access(1, "t3_sw", 32'h100, 32'hCAFE1234, 4'hF, 4'h0, 32'h0, 1'b0, 3);
    access(1, "t3_lh", 32'h102, 32'h0, 4'h0, 4'h3, 32'h0000CAFE, 1'b0, 3);

    // Two wait states: a reset during WAIT aborts the store.
    access(2, "t6_pre", 32'h10, 32'h77, 4'hF, 4'h0, 32'h0, 1'b0, 2);
    v[2] = 1'b1; a[2] = 32'h10; wd[2] = 32'h5; ws[2] = 4'hF; rm[2] = 4'h0;
    @(posedge clk);
    @(negedge clk);
    rst2 = 1'b1;
    any  = rdy[2];
    @(negedge clk);
    rst2 = 1'b0; v[2] = 1'b0; ws[2] = 4'h0;
    any |= rdy[2];
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      any |= rdy[2];
    end
    check("t6_noready", {31'b0, any}, 32'd0);
    access(2, "t6_lw", 32'h10, 32'h0, 4'h0, 4'hF, 32'h00000077, 1'b0, 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
